// File: rtl/pixel_writer.sv
// pixel_writer: debounced button/switch control that paints or clears a
// GRID_W x GRID_H pixel RAM through a single registered write port.
module pixel_writer #(
    parameter int GRID_W     = 8,
    parameter int GRID_H     = 8,
    parameter int ADDR_W     = 6,
    parameter int DEB_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        btn,
    input  logic              switch,
    input  logic [7:0]        color,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [9:0]        cursor_x,
    output logic [9:0]        cursor_y,
    output logic              busy
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0]     DMAX = CW'(DEB_CYCLES - 1);
    localparam logic [9:0]        XMAX = 10'(GRID_W - 1);
    localparam logic [9:0]        YMAX = 10'(GRID_H - 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(GRID_W * GRID_H - 1);

    typedef enum logic [1:0] {IDLE, PAINT, CLEAR} state_t;

    state_t            state, state_n;
    logic [3:0]        sync1, sync2, deb, ev;
    logic [CW-1:0]     cnt [4];
    logic              wr_en_n, busy_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        data_n;
    logic [9:0]        x_n, y_n;

    // Bit order {switch, paint, down, right}; a level flips after DEB_CYCLES disagreeing cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int k = 0; k < 4; k++) cnt[k] <= '0;
        end else begin
            sync1 <= {switch, btn};
            sync2 <= sync1;
            for (int k = 0; k < 4; k++) begin
                if (sync2[k] == deb[k]) cnt[k] <= '0;
                else if (cnt[k] == DMAX) begin
                    cnt[k] <= '0;
                    deb[k] <= sync2[k];
                end else cnt[k] <= cnt[k] + CW'(1);
            end
        end
    end

    // Event fires on the cycle whose edge will raise the debounced level.
    always_comb begin
        for (int k = 0; k < 4; k++) ev[k] = sync2[k] & ~deb[k] & (cnt[k] == DMAX);
    end

    always_comb begin
        state_n = state;
        wr_en_n = 1'b0;
        addr_n  = wr_addr;
        data_n  = wr_data;
        x_n     = cursor_x;
        y_n     = cursor_y;
        case (state)
            IDLE: begin
                if (ev[0]) begin
                    x_n = (cursor_x == XMAX) ? '0 : cursor_x + 10'd1;
                    y_n = (cursor_x != XMAX) ? cursor_y : (cursor_y == YMAX) ? '0 : cursor_y + 10'd1;
                end
                if (ev[1]) y_n = (y_n == YMAX) ? '0 : y_n + 10'd1;
                if (ev[3]) begin
                    state_n = CLEAR;
                    wr_en_n = 1'b1;
                    addr_n  = '0;
                    data_n  = '0;
                end else if (ev[2]) begin
                    state_n = PAINT;
                    wr_en_n = 1'b1;
                    addr_n  = ADDR_W'(cursor_y * GRID_W + cursor_x);
                    data_n  = color;
                end
            end
            PAINT: state_n = IDLE;
            CLEAR: begin
                state_n = (wr_addr == LAST) ? IDLE : CLEAR;
                wr_en_n = (wr_addr != LAST);
                addr_n  = (wr_addr == LAST) ? wr_addr : wr_addr + ADDR_W'(1);
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            wr_en    <= wr_en_n;
            wr_addr  <= addr_n;
            wr_data  <= data_n;
            cursor_x <= x_n;
            cursor_y <= y_n;
            busy     <= busy_n;
        end
    end
endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed vectors for pixel_writer with DEB_CYCLES=4.
module tb_pixel_writer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] btn = '0;
    logic       switch = 1'b0;
    logic [7:0] color = '0;
    logic       wr_en, busy;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [9:0] cursor_x, cursor_y;

    int vectors = 0, miscompares = 0;
    int cyc = 0, busy_cnt = 0;
    int qa[$], qd[$], qc[$];

    pixel_writer #(.DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn(btn), .switch(switch), .color(color),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (wr_en) begin
            qa.push_back(int'(wr_addr));
            qd.push_back(int'(wr_data));
            qc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic flush();
        qa.delete();
        qd.delete();
        qc.delete();
        busy_cnt = 0;
    endtask

    // raw bits: {switch, paint, down, right}
    task automatic press(input logic [3:0] m, input int hold, input int settle);
        @(negedge clk);
        {switch, btn} = m;
        repeat (hold) @(negedge clk);
        {switch, btn} = '0;
        repeat (settle) @(negedge clk);
    endtask

    task automatic tap(input logic [3:0] m, input int n);
        for (int i = 0; i < n; i++) press(m, 8, 12);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int bad, span;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_x", cursor_x, 0);
        chk("rst_y", cursor_y, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        flush();
        color = 8'h3C;
        press(4'b0100, 3, 15);
        chk("short_pulse_writes", qa.size(), 0);
        chk("short_pulse_busy", busy_cnt, 0);

        flush();
        press(4'b0100, 10, 15);
        chk("paint0_writes", qa.size(), 1);
        chk("paint0_addr", qa.size() > 0 ? qa[0] : -1, 0);
        chk("paint0_data", qd.size() > 0 ? qd[0] : -1, 8'h3C);
        chk("paint0_busy", busy_cnt, 1);

        tap(4'b0001, 7);
        chk("r7_x", cursor_x, 7);
        chk("r7_y", cursor_y, 0);
        tap(4'b0001, 1);
        chk("r8_x", cursor_x, 0);
        chk("r8_y", cursor_y, 1);
        tap(4'b0010, 6);
        tap(4'b0001, 7);
        chk("c77_x", cursor_x, 7);
        chk("c77_y", cursor_y, 7);
        tap(4'b0001, 1);
        chk("wrap_x", cursor_x, 0);
        chk("wrap_y", cursor_y, 0);

        tap(4'b0001, 3);
        tap(4'b0010, 2);
        chk("c32_x", cursor_x, 3);
        chk("c32_y", cursor_y, 2);
        flush();
        color = 8'hA5;
        press(4'b0100, 8, 15);
        chk("paint19_writes", qa.size(), 1);
        chk("paint19_addr", qa.size() > 0 ? qa[0] : -1, 19);
        chk("paint19_data", qd.size() > 0 ? qd[0] : -1, 8'hA5);
        chk("paint19_busy", busy_cnt, 1);
        chk("hold_addr", wr_addr, 19);
        chk("hold_data", wr_data, 8'hA5);

        flush();
        @(negedge clk);
        switch = 1'b1;
        repeat (20) @(negedge clk);
        btn[2] = 1'b1;
        repeat (10) @(negedge clk);
        {switch, btn} = '0;
        repeat (80) @(negedge clk);
        bad = 0;
        foreach (qa[i]) if (qa[i] != i || qd[i] != 0) bad++;
        span = qc.size() > 0 ? qc[qc.size()-1] - qc[0] : -1;
        chk("clr_writes", qa.size(), 64);
        chk("clr_seq_bad", bad, 0);
        chk("clr_span", span, 63);
        chk("clr_busy", busy_cnt, 64);
        chk("clr_x", cursor_x, 3);
        chk("clr_y", cursor_y, 2);

        flush();
        color = 8'hFF;
        press(4'b1100, 10, 90);
        bad = 0;
        foreach (qd[i]) if (qd[i] != 0) bad++;
        chk("sim_writes", qa.size(), 64);
        chk("sim_paint_writes", bad, 0);
        chk("sim_busy", busy_cnt, 64);

        flush();
        @(negedge clk);
        switch = 1'b1;
        for (int t = 0; t < 200 && !(wr_en && wr_addr == 6'd20); t++) @(negedge clk);
        chk("abort_reach20", int'(wr_en && wr_addr == 6'd20), 1);
        rst = 1'b0;
        #1;
        chk("abort_wr_en", wr_en, 0);
        chk("abort_addr", wr_addr, 0);
        chk("abort_data", wr_data, 0);
        chk("abort_x", cursor_x, 0);
        chk("abort_y", cursor_y, 0);
        chk("abort_busy", busy, 0);
        switch = 1'b0;
        repeat (3) @(negedge clk);
        flush();
        rst = 1'b1;
        repeat (80) @(negedge clk);
        chk("abort_no_resume", qa.size(), 0);

        rst = 1'b0;
        color = 8'h5A;
        btn[2] = 1'b1;
        repeat (3) @(negedge clk);
        flush();
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("held_writes", qa.size(), 1);
        chk("held_addr", qa.size() > 0 ? qa[0] : -1, 0);
        chk("held_data", qd.size() > 0 ? qd[0] : -1, 8'h5A);
        btn[2] = 1'b0;
        repeat (20) @(negedge clk);
        chk("held_once", qa.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 The block SHALL have parameter GRID_W, default 8, meaning cursor columns.
REQ-002 The block SHALL have parameter GRID_H, default 8, meaning cursor rows.
REQ-003 The block SHALL have parameter ADDR_W, default 6, meaning write-address width, with 2**ADDR_W >= GRID_W*GRID_H.
REQ-004 The block SHALL have parameter DEB_CYCLES, default 250000, meaning debounce stability window in clk cycles (minimum 2).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, rising edge, same domain as the RAM write port.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port btn, input, 3 bits, raw asynchronous buttons, active-high: [0] move right, [1] move down, [2] paint.
REQ-008 The block SHALL have port switch, input, 1 bit, raw asynchronous clear request; a rising edge of the debounced level starts a clear.
REQ-009 The block SHALL have port color, input, 8 bits: paint data, sampled on the paint-event cycle.
REQ-010 The block SHALL have port wr_en, output, 1 bit: RAM write strobe, one write per high cycle.
REQ-011 The block SHALL have port wr_addr, output, ADDR_W bits: RAM write address.
REQ-012 The block SHALL have port wr_data, output, 8 bits: RAM write data.
REQ-013 The block SHALL have port cursor_x, output, 10 bits: current cursor column, zero-extended.
REQ-014 The block SHALL have port cursor_y, output, 10 bits: current cursor row, zero-extended.
REQ-015 The block SHALL have port busy, output, 1 bit: high while in PAINT or CLEAR.

Function
REQ-016 Each of btn[2:0] and switch SHALL pass through a 2-flop synchronizer, then a per-input debouncer.
REQ-017 Each debounced level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any agreeing cycle resets that input's counter.
REQ-018 A debounced rising edge SHALL produce exactly one single-cycle event pulse; holding an input SHALL NOT repeat the event.
REQ-019 The FSM SHALL have states IDLE, PAINT and CLEAR.
REQ-020 In IDLE, the FSM SHALL service events with priority clear > paint; move events SHALL be serviced in the same cycle as a paint event.
REQ-021 On a paint event in IDLE, the block SHALL latch wr_addr = cursor_y*GRID_W + cursor_x using pre-move cursor values, latch wr_data = color, and go to PAINT.
REQ-022 PAINT SHALL last exactly one cycle with wr_en=1, then return to IDLE.
REQ-023 Write latency SHALL be 1 cycle from event pulse to the wr_en cycle.
REQ-024 On a clear event in IDLE, the FSM SHALL go to CLEAR; a simultaneous paint SHALL be dropped, and simultaneous moves SHALL still apply.
REQ-025 CLEAR SHALL assert wr_en for GRID_W*GRID_H consecutive cycles with wr_addr 0,1,2,...,GRID_W*GRID_H-1 and wr_data 0x00, then return to IDLE.
REQ-026 The cursor SHALL be unchanged by a clear.
REQ-027 A move-right event SHALL increment cursor_x; at GRID_W-1 it SHALL wrap to 0 and cursor_y SHALL increment, wrapping from GRID_H-1 to 0.
REQ-028 A move-down event SHALL increment cursor_y, wrapping from GRID_H-1 to 0, with cursor_x unchanged.
REQ-029 Simultaneous right and down events SHALL apply right, including any wrap, then down.
REQ-030 All events arriving while in PAINT or CLEAR SHALL be discarded, not queued.
REQ-031 When wr_en=0, wr_addr and wr_data SHALL hold their last values.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 While rst=0, the block SHALL asynchronously set: FSM=IDLE, wr_en=0, wr_addr=0, wr_data=0, cursor_x=0, cursor_y=0, busy=0, all synchronizers, debounced levels and debounce counters =0.
REQ-034 Assertion of rst during CLEAR or PAINT SHALL abort the operation with no further writes.
REQ-035 After rst deasserts, an input already held high SHALL generate its event once it has been debounced.

Verification (sim with DEB_CYCLES=4, defaults otherwise)
REQ-036 The bench SHALL cover: btn[2] pulse of 3 cycles -> no event and no wr_en ever; held 10 cycles -> exactly one wr_en with addr 0 and data = color.
REQ-037 The bench SHALL cover: 7 right presses then 1 more -> cursor (7,0) then (0,1); right press at (7,7) -> (0,0).
REQ-038 The bench SHALL cover: cursor (3,2) with color 0xA5 and paint -> wr_addr 19, wr_data 0xA5, single-cycle wr_en, busy high 1 cycle.
REQ-039 The bench SHALL cover: switch rise -> 64 consecutive wr_en cycles, addr 0..63, data 0x00, busy high 64 cycles; a paint pressed mid-clear -> no extra write after clear.
REQ-040 The bench SHALL cover: simultaneous clear and paint debounced edges -> clear only, 64 writes, no paint write.
REQ-041 The bench SHALL cover: rst low at clear address 20 -> wr_en drops immediately and all outputs read reset values; no writes resume after rst release.
